// File: rtl/typed_state_tx.sv
// Small FIFO of typed state values with a registered "last delivered" copy.
// Width is taken from state_t, so the values can be enums, including undeclared encodings.
module typed_state_tx #(
  parameter type    state_t     = logic [8:0],
  parameter state_t RESET_VALUE = state_t'('0),
  parameter int     DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  state_t                     push_data_i,
  output logic                       state_valid_o,
  input  logic                       state_ready_i,
  output state_t                     state_o,
  output state_t                     held_state_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int LvlW = $clog2(DEPTH+1);

  state_t            mem [DEPTH];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [LvlW-1:0]   level;
  state_t            heldState;
  logic              pushFire;
  logic              popFire;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Both ready and valid depend only on the registered level, so there is
  // no combinational path from either side's valid/ready to the other's.
  assign push_ready_o  = (level < LvlW'(DEPTH));
  assign state_valid_o = (level != '0);
  assign pushFire      = push_valid_i && push_ready_o;
  assign popFire       = state_valid_o && state_ready_i;

  // Unregistered peek; once empty, fall back to the last delivered value.
  assign state_o      = state_valid_o ? mem[rdPtr] : heldState;
  assign held_state_o = heldState;
  assign level_o      = level;

  // Storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (pushFire && !rst_i) begin
      mem[wrPtr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      level     <= '0;
      heldState <= RESET_VALUE;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (popFire) begin
        rdPtr     <= rdPtr + PtrW'(1);
        heldState <= mem[rdPtr];
      end
      case ({pushFire, popFire})
        2'b10:   level <= level + LvlW'(1);
        2'b01:   level <= level - LvlW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_typed_state_tx.sv
// Bench for typed_state_tx: an 8-bit enum instance for basic latency and a
// 9-bit instance driven by a vector table, a scoreboard phase and a reset corner.
module tb_typed_state_tx;

  typedef enum logic [7:0] {ST_IDLE = 8'h00, ST_RUN = 8'h01, ST_DONE = 8'h80} e8_t;
  localparam logic [8:0] RV9 = 9'h155;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 9-bit instance
  logic       rst9, pv9, sr9, pr9, sv9;
  logic [8:0] pd9, st9, held9;
  logic [2:0] lvl9;

  // 8-bit enum instance
  logic       rst8, pv8, sr8, pr8, sv8;
  e8_t        pd8, st8, held8;
  logic [2:0] lvl8;

  typed_state_tx #(.state_t(logic [8:0]), .RESET_VALUE(RV9), .DEPTH(4)) dut9 (
    .clk_i(clk), .rst_i(rst9), .push_valid_i(pv9), .push_ready_o(pr9),
    .push_data_i(pd9), .state_valid_o(sv9), .state_ready_i(sr9),
    .state_o(st9), .held_state_o(held9), .level_o(lvl9)
  );

  typed_state_tx #(.state_t(e8_t), .DEPTH(4)) dut8 (
    .clk_i(clk), .rst_i(rst8), .push_valid_i(pv8), .push_ready_o(pr8),
    .push_data_i(pd8), .state_valid_o(sv8), .state_ready_i(sr8),
    .state_o(st8), .held_state_o(held8), .level_o(lvl8)
  );

  typedef struct {
    logic       rst;
    logic       pv;
    logic [8:0] pd;
    logic       sr;
    logic [2:0] lvl;
    logic       vld;
    logic       rdy;
    logic [8:0] st;
    logic [8:0] held;
  } vec_t;

  vec_t       vecs [12];
  logic [8:0] exp_q [$];
  int         nChecks = 0;
  int         nFails  = 0;
  int         mLevel  = 0;
  logic [8:0] lastPop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 9-bit instance, predicted by an independent level/queue model.
  task automatic cycle9(input logic pv, input logic [8:0] d, input logic sr);
    logic pushF, popF;
    logic [8:0] e;
    rst9 = 1'b0; pv9 = pv; pd9 = d; sr9 = sr;
    pushF = pv && (mLevel < 4);
    popF  = sr && (mLevel != 0);
    chk("sb_valid", sv9, mLevel != 0);
    chk("sb_ready", pr9, mLevel < 4);
    if (popF) begin
      e = exp_q.pop_front();
      chk("sb_data", st9, e);
      lastPop = e;
    end
    if (pushF) exp_q.push_back(d);
    tick();
    mLevel = mLevel + int'(pushF) - int'(popF);
    chk("sb_level", lvl9, mLevel);
    if (popF) chk("sb_held", held9, lastPop);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 9'h077, 1'b1, 3'd0, 1'b0, 1'b1, 9'h155, 9'h155};
    vecs[1]  = '{1'b1, 1'b0, 9'h000, 1'b0, 3'd0, 1'b0, 1'b1, 9'h155, 9'h155};
    vecs[2]  = '{1'b0, 1'b1, 9'h121, 1'b1, 3'd1, 1'b1, 1'b1, 9'h121, 9'h155};
    vecs[3]  = '{1'b0, 1'b1, 9'h001, 1'b0, 3'd2, 1'b1, 1'b1, 9'h121, 9'h155};
    vecs[4]  = '{1'b0, 1'b1, 9'h1FF, 1'b0, 3'd3, 1'b1, 1'b1, 9'h121, 9'h155};
    vecs[5]  = '{1'b0, 1'b1, 9'h0AA, 1'b0, 3'd4, 1'b1, 1'b0, 9'h121, 9'h155};
    vecs[6]  = '{1'b0, 1'b1, 9'h033, 1'b0, 3'd4, 1'b1, 1'b0, 9'h121, 9'h155};
    vecs[7]  = '{1'b0, 1'b1, 9'h033, 1'b1, 3'd3, 1'b1, 1'b1, 9'h001, 9'h121};
    vecs[8]  = '{1'b0, 1'b0, 9'h000, 1'b1, 3'd2, 1'b1, 1'b1, 9'h1FF, 9'h001};
    vecs[9]  = '{1'b0, 1'b0, 9'h000, 1'b1, 3'd1, 1'b1, 1'b1, 9'h0AA, 9'h1FF};
    vecs[10] = '{1'b0, 1'b0, 9'h000, 1'b1, 3'd0, 1'b0, 1'b1, 9'h0AA, 9'h0AA};
    vecs[11] = '{1'b0, 1'b1, 9'h044, 1'b0, 3'd1, 1'b1, 1'b1, 9'h044, 9'h0AA};

    rst9 = 1'b1; pv9 = 1'b0; pd9 = '0; sr9 = 1'b0;
    rst8 = 1'b1; pv8 = 1'b0; pd8 = ST_IDLE; sr8 = 1'b0;
    tick();
    tick();
    rst8 = 1'b0;

    // Enum instance: reset state, 1-cycle latency, delivery into held_state_o
    chk("e8_rst_level", lvl8, 0);
    chk("e8_rst_valid", sv8, 0);
    chk("e8_rst_ready", pr8, 1);
    chk("e8_rst_held", held8, 8'h00);
    chk("e8_rst_state", st8, 8'h00);
    pv8 = 1'b1; pd8 = e8_t'(8'h95); sr8 = 1'b0;
    chk("e8_no_fallthrough", sv8, 0);
    tick();
    pv8 = 1'b0;
    chk("e8_push_valid", sv8, 1);
    chk("e8_push_state", st8, 8'h95);
    chk("e8_push_level", lvl8, 1);
    chk("e8_push_held", held8, 8'h00);
    sr8 = 1'b1;
    tick();
    sr8 = 1'b0;
    chk("e8_pop_held", held8, 8'h95);
    chk("e8_pop_level", lvl8, 0);
    chk("e8_pop_valid", sv8, 0);

    // Table: reset priority, fill, stalled push, full push+pop, drain, wrap
    for (int i = 0; i < 12; i++) begin
      rst9 = vecs[i].rst; pv9 = vecs[i].pv; pd9 = vecs[i].pd; sr9 = vecs[i].sr;
      tick();
      chk($sformatf("vec%0d_level", i), lvl9, vecs[i].lvl);
      chk($sformatf("vec%0d_valid", i), sv9, vecs[i].vld);
      chk($sformatf("vec%0d_ready", i), pr9, vecs[i].rdy);
      chk($sformatf("vec%0d_state", i), st9, vecs[i].st);
      chk($sformatf("vec%0d_held", i), held9, vecs[i].held);
    end

    // Scoreboard: continuous push+pop at level 2, then random traffic, then drain
    mLevel = 1;
    exp_q.push_back(9'h044);
    cycle9(1'b1, 9'($urandom_range(0, 511)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle9(1'b1, 9'($urandom_range(0, 511)), 1'b1);
      chk("steady_level2", lvl9, 2);
    end
    for (int i = 0; i < 300; i++)
      cycle9(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) cycle9(1'b0, 9'h000, 1'b1);
    chk("drained_queue", exp_q.size(), 0);

    // Reset while holding three entries with a simultaneous pop
    for (int i = 0; i < 3; i++) cycle9(1'b1, 9'($urandom_range(0, 511)), 1'b0);
    chk("pre_rst_level", lvl9, 3);
    rst9 = 1'b1; pv9 = 1'b0; sr9 = 1'b1;
    tick();
    chk("midrst_level", lvl9, 0);
    chk("midrst_held", held9, RV9);
    chk("midrst_valid", sv9, 0);
    chk("midrst_state", st9, RV9);
    chk("midrst_ready", pr9, 1);
    rst9 = 1'b0;
    tick();
    sr9 = 1'b0;
    chk("postrst_valid", sv9, 0);
    chk("postrst_held", held9, RV9);
    chk("postrst_level", lvl9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/typed_state_tx.md
TYPED_STATE_TX -- requirements
Module: typed_state_tx

Interface
REQ-001 SHALL have parameter: state_t, type, default logic [8:0], type of every state value carried; may be a packed enum of any width.
REQ-002 SHALL have parameter: RESET_VALUE, state_t, default state_t'('0), value of held_state_o after reset.
REQ-003 SHALL have parameter: DEPTH, int, default 4, number of buffer entries; power of two, 2..64.
REQ-004 SHALL have port: clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: push_valid_i  input  1  producer offers push_data_i.
REQ-007 SHALL have port: push_ready_o  output  1  buffer can accept an entry.
REQ-008 SHALL have port: push_data_i  input  state_t  value offered.
REQ-009 SHALL have port: state_valid_o  output  1  state_o holds a valid head entry.
REQ-010 SHALL have port: state_ready_i  input  1  consumer accepts state_o.
REQ-011 SHALL have port: state_o  output  state_t  head entry, unregistered peek of the buffer.
REQ-012 SHALL have port: held_state_o  output  state_t  registered copy of the last value delivered.
REQ-013 SHALL have port: level_o  output  $clog2(DEPTH+1)  current entry count.

Function
REQ-014 SHALL accept a push when push_valid_i && push_ready_o at a rising edge.
REQ-015 SHALL perform a pop when state_valid_o && state_ready_i at a rising edge.
REQ-016 SHALL drive push_ready_o = (level_o < DEPTH), purely from registered state, with no combinational path from state_ready_i.
REQ-017 SHALL drive state_valid_o = (level_o != 0), with no combinational path from push_valid_i; a pushed entry becomes visible on the next cycle, giving 1-cycle minimum latency.
REQ-018 SHALL present state_o as the oldest entry while state_valid_o=1, and as held_state_o while state_valid_o=0.
REQ-019 SHALL preserve order strictly FIFO, carrying each value bit-exact, including enum encodings not among declared literals.
REQ-020 SHALL keep separate write and read pointers of $clog2(DEPTH) bits, each wrapping DEPTH-1 -> 0 without a gap.
REQ-021 SHALL, on a pop, load held_state_o with the popped value on the same edge.
REQ-022 SHALL, on a simultaneous push and pop, leave level_o unchanged.
REQ-023 SHALL, when full, accept a simultaneous push and pop only if push_ready_o was 1; since it is 0 when full, the push SHALL be stalled while the pop completes.
REQ-024 SHALL, when empty, not allow a same-cycle push to bypass to state_o (no fall-through).
REQ-025 SHALL change level_o by +1 on push only, -1 on pop only, and never exceed DEPTH or go below 0.
REQ-026 SHALL keep state_o, state_valid_o and held_state_o stable while state_valid_o=1 and state_ready_i=0.
REQ-027 SHALL derive width solely from $bits(state_t); no other width parameter.

Reset
REQ-028 SHALL, when rst_i=1 at a rising edge, clear both pointers and level_o to 0, set held_state_o to RESET_VALUE, and discard all entries.
REQ-029 SHALL, during and after reset, drive state_valid_o=0, push_ready_o=1, and state_o=RESET_VALUE.
REQ-030 SHALL give reset priority over a simultaneous push or pop: neither takes effect, and held_state_o is not updated.
REQ-031 SHALL leave buffer storage unreset; only pointers, level and held_state_o are reset.

Verification
REQ-032 SHALL cover post-reset: rst_i=1 for 2 cycles then 0 -> level_o=0, state_valid_o=0, push_ready_o=1, held_state_o=RESET_VALUE.
REQ-033 SHALL cover an 8-bit enum state_t, DEPTH=4: push 8'h95 with state_ready_i=0 -> state_valid_o=1 next cycle, state_o=8'h95, level_o=1; then state_ready_i=1 -> held_state_o=8'h95, level_o=0.
REQ-034 SHALL cover a 9-bit state_t: push 9'h121, 9'h001, 9'h1FF, 9'h0AA with no pop -> level_o=4, push_ready_o=0; a fifth push is stalled; 4 pops return the values in order.
REQ-035 SHALL cover full with push_valid_i=1 and state_ready_i=1 -> the pop completes, push_ready_o=1 next cycle, level_o=3.
REQ-036 SHALL cover continuous push+pop for 10 cycles at level 2 -> level_o stays 2, and both pointers wrap past DEPTH-1 with order intact.
REQ-037 SHALL cover reset mid-operation: rst_i=1 while level_o=3 with a simultaneous pop -> next cycle level_o=0, held_state_o=RESET_VALUE, and no value is delivered.
